// File: rtl/tpsram_bist_pkg.sv
// Shared types and helpers for the TPSRAM BIST sequencer.
// Optional feature macro: TPSRAM_BIST_AUTO_RESTART_EN adds the RST state.
package tpsram_bist_pkg;

    localparam int unsigned DEF_ADDR_W = 6;
    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEPTH      = 2 ** DEF_ADDR_W;

    typedef enum logic [3:0] {
        IDLE,
        WR0,
        RD0,
        DRN0,
        WR1,
        RD1,
        DRN1,
        FIN
`ifdef TPSRAM_BIST_AUTO_RESTART_EN
        ,
        RST
`endif
    } state_t;

    // March pattern: address XOR seed, inverted for the second phase.
    // Callers size-cast the result to their data width; the address is
    // zero-extended before the XOR.
    function automatic logic [31:0] pat(input logic [31:0] addr,
                                        input logic [31:0] seed,
                                        input logic        phase);
        logic [31:0] p;
        p = addr ^ seed;
        return phase ? ~p : p;
    endfunction

endpackage

// File: rtl/tpsram_bist_cmp.sv
// One-stage read-compare pipe: captures the read address and phase when a
// read is issued, then checks the returned data against the pattern.
module tpsram_bist_cmp
    import tpsram_bist_pkg::*;
#(
    parameter int unsigned       ADDR_W = 6,
    parameter int unsigned       DATA_W = 8,
    parameter logic [DATA_W-1:0] SEED   = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              capture,
    input  logic [ADDR_W-1:0] addr,
    input  logic              phase,
    input  logic [DATA_W-1:0] rd,
    output logic              mismatch,
    output logic [ADDR_W-1:0] mismatch_addr
);

    logic              valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic              phase_q;
    logic [DATA_W-1:0] expected;

    // Pipe register: RD arrives one cycle after REN, so hold the address.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            valid_q <= capture;
            addr_q  <= addr;
            phase_q <= phase;
        end
    end

    // Compare returned data against the pattern of the piped address.
    always_comb begin
        expected      = DATA_W'(pat(32'(addr_q), 32'(SEED), phase_q));
        mismatch      = valid_q && (rd != expected);
        mismatch_addr = addr_q;
    end

endmodule

// File: rtl/tpsram_bist_seq.sv
// TPSRAM BIST sequencer: two-phase write/read-back march (P then ~P) over
// the whole RAM, reporting PASS and the first failing address.
// Optional feature macro: TPSRAM_BIST_AUTO_RESTART_EN (pulse RESTART_N low
// for RESTART_HOLD cycles after a clean pass).
module tpsram_bist_seq
    import tpsram_bist_pkg::*;
#(
    parameter int unsigned       ADDR_W       = 6,
    parameter int unsigned       DATA_W       = 8,
    parameter logic [DATA_W-1:0] SEED         = 8'hA5,
    parameter int unsigned       RESTART_HOLD = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    output logic              BUSY,
    output logic              DONE,
    output logic              PASS,
    output logic [ADDR_W-1:0] FAIL_ADDR,
    output logic [ADDR_W-1:0] WADDR,
    output logic [DATA_W-1:0] WD,
    output logic              WEN,
    output logic [ADDR_W-1:0] RADDR,
    output logic              REN,
    input  logic [DATA_W-1:0] RD,
    output logic              RESTART_N
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              cnt_last;
    logic              phase;
    logic              fail_q;
    logic              pass_q;
    logic [ADDR_W-1:0] fail_addr_q;
    logic              mismatch;
    logic [ADDR_W-1:0] mismatch_addr;
    logic              fail_hit;
    logic              start_ok;

    assign cnt_last = (cnt_q == '1);
    assign start_ok = (state_q == IDLE) && START;

    tpsram_bist_cmp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .SEED   (SEED)
    ) u_cmp (
        .clk           (CLK),
        .reset         (RESET),
        .capture       (REN),
        .addr          (RADDR),
        .phase         (phase),
        .rd            (RD),
        .mismatch      (mismatch),
        .mismatch_addr (mismatch_addr)
    );

`ifdef TPSRAM_BIST_AUTO_RESTART_EN
    localparam int unsigned HOLD_W = (RESTART_HOLD > 1) ? $clog2(RESTART_HOLD) : 1;

    logic [HOLD_W-1:0] hold_q;
    logic              hold_last;

    assign hold_last = (hold_q == HOLD_W'(RESTART_HOLD - 1));
    assign RESTART_N = (state_q != RST);

    // Hold counter: runs only while in RST, otherwise parked at zero.
    always_ff @(posedge CLK) begin
        if (RESET || state_q != RST) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_q + 1'b1;
        end
    end
`else
    assign RESTART_N = 1'b1;
`endif

    // Next-state, address counter and RAM port drive.
    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        phase    = 1'b0;
        BUSY     = 1'b0;
        DONE     = 1'b0;
        WEN      = 1'b0;
        WADDR    = '0;
        WD       = '0;
        REN      = 1'b0;
        RADDR    = '0;
        fail_hit = 1'b0;

        case (state_q)
            IDLE: begin
                if (START) begin
                    state_d = WR0;
                end
            end
            WR0, WR1: begin
                phase = (state_q == WR1);
                BUSY  = 1'b1;
                WEN   = 1'b1;
                WADDR = cnt_q;
                WD    = DATA_W'(pat(32'(cnt_q), 32'(SEED), phase));
                cnt_d = cnt_q + 1'b1;
                if (cnt_last) begin
                    cnt_d   = '0;
                    state_d = (state_q == WR0) ? RD0 : RD1;
                end
            end
            RD0, RD1: begin
                phase    = (state_q == RD1);
                BUSY     = 1'b1;
                REN      = 1'b1;
                RADDR    = cnt_q;
                fail_hit = mismatch;
                cnt_d    = cnt_q + 1'b1;
                if (mismatch) begin
                    cnt_d   = '0;
                    state_d = FIN;
                end else if (cnt_last) begin
                    cnt_d   = '0;
                    state_d = (state_q == RD0) ? DRN0 : DRN1;
                end
            end
            DRN0: begin
                BUSY     = 1'b1;
                fail_hit = mismatch;
                state_d  = mismatch ? FIN : WR1;
            end
            DRN1: begin
                phase    = 1'b1;
                BUSY     = 1'b1;
                fail_hit = mismatch;
                state_d  = FIN;
            end
            FIN: begin
                DONE    = 1'b1;
                state_d = IDLE;
`ifdef TPSRAM_BIST_AUTO_RESTART_EN
                if (!fail_q) begin
                    state_d = RST;
                end
`endif
            end
`ifdef TPSRAM_BIST_AUTO_RESTART_EN
            RST: begin
                if (hold_last) begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and result registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            fail_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_addr_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (start_ok) begin
                fail_q      <= 1'b0;
                pass_q      <= 1'b0;
                fail_addr_q <= '0;
            end else begin
                if (fail_hit && !fail_q) begin
                    fail_q      <= 1'b1;
                    fail_addr_q <= mismatch_addr;
                end
                if (state_q == FIN) begin
                    pass_q <= !fail_q;
                end
            end
        end
    end

    // PASS is presented in the DONE cycle itself, then held in pass_q.
    assign PASS      = (state_q == FIN) ? !fail_q : pass_q;
    assign FAIL_ADDR = fail_addr_q;

endmodule
